// File: rtl/seq101_moore_detector.sv
// Serial "101" pattern detector, Moore FSM with a registered match flag.
// OVERLAP selects whether the trailing 1 of a match may start the next one.
module seq101_moore_detector #(
    parameter int unsigned OVERLAP = 1
) (
    output logic z,
    input  logic w,
    input  logic Reset,
    input  logic Clk
);

    typedef enum logic [1:0] {
        S0 = 2'd0,
        S1 = 2'd1,
        S2 = 2'd2,
        S3 = 2'd3
    } state_t;

    state_t state_q, state_d;
    logic   z_q, z_d;

    // State and flag share one edge so z is a clean flop output
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= S0;
            z_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            z_q     <= z_d;
        end
    end

    always_comb begin
        state_d = S0;
        z_d     = 1'b0;
        case (state_q)
            S0: state_d = w ? S1 : S0;
            S1: state_d = w ? S1 : S2;
            S2: state_d = w ? S3 : S0;
            S3: begin
                if (w)
                    state_d = S1;
                else
                    state_d = (OVERLAP != 0) ? S2 : S0;
            end
            default: state_d = S0;
        endcase
        // Flag mirrors the state being entered, keeping z a pure Moore output
        z_d = (state_d == S3);
    end

    assign z = z_q;

endmodule

// File: tb/tb_seq101_moore_detector.sv
// Directed bench for seq101_moore_detector; runs an overlapping and a
// non-overlapping instance side by side on the same bit stream.
module tb_seq101_moore_detector;

    logic clk;
    logic reset;
    logic w;
    logic z_ov;
    logic z_no;

    int checks;
    int errors;

    seq101_moore_detector #(.OVERLAP(1)) dut_ov (
        .z     (z_ov),
        .w     (w),
        .Reset (reset),
        .Clk   (clk)
    );

    seq101_moore_detector #(.OVERLAP(0)) dut_no (
        .z     (z_no),
        .w     (w),
        .Reset (reset),
        .Clk   (clk)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive on the falling edge, then sample 1 time unit after the rising edge
    task automatic cycle(input logic wi, input logic ri);
        @(negedge clk);
        w     = wi;
        reset = ri;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        cycle(1'b0, 1'b1);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            cycle(1'b1, 1'b1);
            checks++;
            if (z_ov !== 1'b0 || z_no !== 1'b0) begin
                errors++;
                $display("FAIL reset_hold edge %0d: z_ov=%b z_no=%b expected 0", i, z_ov, z_no);
            end
        end
        // State S0 after release: a lone 0,1 must not complete a match
        cycle(1'b0, 1'b0);
        cycle(1'b1, 1'b0);
        checks++;
        if (z_ov !== 1'b0 || z_no !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: z_ov=%b z_no=%b expected 0", z_ov, z_no);
        end
    endtask

    task automatic test_basic();
        logic [0:3] wv, ev;
        wv = 4'b1011;
        ev = 4'b0010;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            cycle(wv[i], 1'b0);
            checks++;
            if (z_ov !== ev[i] || z_no !== ev[i]) begin
                errors++;
                $display("FAIL basic edge %0d: z_ov=%b z_no=%b expected %b", i + 1, z_ov, z_no, ev[i]);
            end
        end
    endtask

    task automatic test_overlap();
        logic [0:4] wv, ev_ov, ev_no;
        wv    = 5'b10101;
        ev_ov = 5'b00101;
        ev_no = 5'b00100;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            cycle(wv[i], 1'b0);
            checks++;
            if (z_ov !== ev_ov[i] || z_no !== ev_no[i]) begin
                errors++;
                $display("FAIL overlap edge %0d: z_ov=%b z_no=%b expected %b/%b",
                         i + 1, z_ov, z_no, ev_ov[i], ev_no[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [0:6] wv, ev_ov, ev_no;
        wv    = 7'b1010101;
        ev_ov = 7'b0010101;
        ev_no = 7'b0010001;
        do_reset();
        for (int i = 0; i < 7; i++) begin
            cycle(wv[i], 1'b0);
            checks++;
            if (z_ov !== ev_ov[i] || z_no !== ev_no[i]) begin
                errors++;
                $display("FAIL back_to_back edge %0d: z_ov=%b z_no=%b expected %b/%b",
                         i + 1, z_ov, z_no, ev_ov[i], ev_no[i]);
            end
        end
    endtask

    task automatic test_prefix();
        logic [0:3] wa, ea;
        logic [0:5] wb, eb;
        wa = 4'b1101;
        ea = 4'b0001;
        wb = 6'b011011;
        eb = 6'b000010;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            cycle(wa[i], 1'b0);
            checks++;
            if (z_ov !== ea[i] || z_no !== ea[i]) begin
                errors++;
                $display("FAIL prefix_a edge %0d: z_ov=%b z_no=%b expected %b", i + 1, z_ov, z_no, ea[i]);
            end
        end
        do_reset();
        for (int i = 0; i < 6; i++) begin
            cycle(wb[i], 1'b0);
            checks++;
            if (z_ov !== eb[i] || z_no !== eb[i]) begin
                errors++;
                $display("FAIL prefix_b edge %0d: z_ov=%b z_no=%b expected %b", i + 1, z_ov, z_no, eb[i]);
            end
        end
    endtask

    task automatic test_non_match();
        logic [0:5] wv;
        wv = 6'b100100;
        do_reset();
        for (int i = 0; i < 6; i++) begin
            cycle(wv[i], 1'b0);
            checks++;
            if (z_ov !== 1'b0 || z_no !== 1'b0) begin
                errors++;
                $display("FAIL non_match edge %0d: z_ov=%b z_no=%b expected 0", i + 1, z_ov, z_no);
            end
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        cycle(1'b1, 1'b0);
        cycle(1'b0, 1'b0);
        // Reset coincides with the completing 1: reset must win
        cycle(1'b1, 1'b1);
        checks++;
        if (z_ov !== 1'b0 || z_no !== 1'b0) begin
            errors++;
            $display("FAIL reset_collide: z_ov=%b z_no=%b expected 0", z_ov, z_no);
        end
        cycle(1'b1, 1'b0);
        checks++;
        if (z_ov !== 1'b0 || z_no !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_restart: z_ov=%b z_no=%b expected 0", z_ov, z_no);
        end
        // From S1, a 0 then 1 completes a match, proving the state was S1
        cycle(1'b0, 1'b0);
        checks++;
        if (z_ov !== 1'b0 || z_no !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_s2: z_ov=%b z_no=%b expected 0", z_ov, z_no);
        end
        cycle(1'b1, 1'b0);
        checks++;
        if (z_ov !== 1'b1 || z_no !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_s1: z_ov=%b z_no=%b expected 1", z_ov, z_no);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        w      = 1'b0;
        reset  = 1'b1;
        test_reset();
        test_basic();
        test_overlap();
        test_back_to_back();
        test_prefix();
        test_non_match();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
